// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 decoder: turns receiver bytes into make/break key
// events, tracks shift/ctrl/alt, and queues events in a show-ahead FIFO.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          scan_ready,
    input  logic [7:0]                    scan_code,
    output logic                          event_valid,
    input  logic                          event_ready,
    output logic [9:0]                    event_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          shift,
    output logic                          ctrl,
    output logic                          alt,
    output logic                          overflow,
    input  logic                          clear_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_PAUSE
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       skip, skip_nxt;
    logic             scan_ready_q;
    logic             byte_acc;
    logic             emit;
    logic [9:0]       emit_data;
    logic             lshift, rshift, lctrl, rctrl, lalt, ralt;
    logic [9:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic             full, push, pop;

    assign byte_acc = scan_ready & ~scan_ready_q;

    // Edge detector on the receiver's ready level; resets high so a level
    // already asserted at reset release is not taken as a new byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) scan_ready_q <= 1'b1;
        else          scan_ready_q <= scan_ready;
    end

    // Parser state and pause byte counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            skip  <= '0;
        end else begin
            state <= state_nxt;
            skip  <= skip_nxt;
        end
    end

    // Prefix parsing: one step per accepted byte, producing at most one event.
    always_comb begin
        state_nxt = state;
        skip_nxt  = skip;
        emit      = 1'b0;
        emit_data = '0;
        if (byte_acc) begin
            case (state)
                S_IDLE: begin
                    if (scan_code == 8'hE0) state_nxt = S_EXT;
                    else if (scan_code == 8'hF0) state_nxt = S_BRK;
                    else if (scan_code == 8'hE1) begin
                        state_nxt = S_PAUSE;
                        skip_nxt  = 3'd7;
                    end else if (scan_code != 8'h00 && scan_code != 8'hFF) begin
                        emit      = 1'b1;
                        emit_data = {2'b00, scan_code};
                    end
                end
                S_EXT: begin
                    if (scan_code == 8'hF0) state_nxt = S_EXT_BRK;
                    else if (scan_code == 8'hE0) state_nxt = S_EXT;
                    else begin
                        state_nxt = S_IDLE;
                        if (scan_code != 8'h12 && scan_code != 8'h59) begin
                            emit      = 1'b1;
                            emit_data = {2'b01, scan_code};
                        end
                    end
                end
                S_BRK: begin
                    state_nxt = S_IDLE;
                    emit      = 1'b1;
                    emit_data = {2'b10, scan_code};
                end
                S_EXT_BRK: begin
                    state_nxt = S_IDLE;
                    if (scan_code != 8'h12 && scan_code != 8'h59) begin
                        emit      = 1'b1;
                        emit_data = {2'b11, scan_code};
                    end
                end
                S_PAUSE: begin
                    skip_nxt = skip - 3'd1;
                    if (skip <= 3'd1) begin
                        state_nxt = S_IDLE;
                        emit      = 1'b1;
                        emit_data = {2'b01, 8'h77};
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Modifier flags follow every emitted event, even one the FIFO drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lshift <= 1'b0;
            rshift <= 1'b0;
            lctrl  <= 1'b0;
            rctrl  <= 1'b0;
            lalt   <= 1'b0;
            ralt   <= 1'b0;
        end else if (emit) begin
            case (emit_data[8:0])
                {1'b0, 8'h12}: lshift <= ~emit_data[9];
                {1'b0, 8'h59}: rshift <= ~emit_data[9];
                {1'b0, 8'h14}: lctrl  <= ~emit_data[9];
                {1'b1, 8'h14}: rctrl  <= ~emit_data[9];
                {1'b0, 8'h11}: lalt   <= ~emit_data[9];
                {1'b1, 8'h11}: ralt   <= ~emit_data[9];
                default: ;
            endcase
        end
    end

    assign shift = lshift | rshift;
    assign ctrl  = lctrl | rctrl;
    assign alt   = lalt | ralt;

    assign full        = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
    assign event_valid = (fifo_count != '0);
    assign pop         = event_valid & event_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push        = emit & (~full | pop);
    assign event_data  = event_valid ? mem[rd_ptr] : '0;

    // FIFO pointers, occupancy and sticky overflow (set beats clear).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
            if (emit & ~push)        overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;
        end
    end

    // Event storage; contents are qualified by the occupancy count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= emit_data;
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed vector table, overflow
// and reset sequences, then random byte traffic against a queue-based model.
module tb_ps2_key_decoder;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       scan_ready;
    logic [7:0] scan_code;
    logic       event_valid;
    logic       event_ready;
    logic [9:0] event_data;
    logic [3:0] fifo_count;
    logic       shift, ctrl, alt, overflow;
    logic       clear_overflow;

    always #5 clk = ~clk;

    ps2_key_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .scan_ready(scan_ready),
        .scan_code(scan_code),
        .event_valid(event_valid),
        .event_ready(event_ready),
        .event_data(event_data),
        .fifo_count(fifo_count),
        .shift(shift),
        .ctrl(ctrl),
        .alt(alt),
        .overflow(overflow),
        .clear_overflow(clear_overflow)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: event queue, set of held keys, prefix flags.
    logic [9:0] m_q[$];
    bit         m_held[512];
    bit         m_ovf;
    bit         m_prev_sr;
    bit         m_ext, m_brk;
    int         m_pause;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        foreach (m_held[i]) m_held[i] = 1'b0;
        m_ovf     = 1'b0;
        m_prev_sr = 1'b1;
        m_ext     = 1'b0;
        m_brk     = 1'b0;
        m_pause   = 0;
    endtask

    task automatic model_parse(input logic [7:0] b, output bit em, output logic [9:0] ev);
        bit fake;
        em   = 1'b0;
        ev   = '0;
        fake = (b == 8'h12 || b == 8'h59);
        if (m_pause > 0) begin
            m_pause--;
            if (m_pause == 0) begin em = 1'b1; ev = 10'h177; end
        end else if (m_brk) begin
            if (!(m_ext && fake)) begin em = 1'b1; ev = {1'b1, m_ext, b}; end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else if (m_ext) begin
            if (b == 8'hF0) m_brk = 1'b1;
            else if (b != 8'hE0) begin
                if (!fake) begin em = 1'b1; ev = {2'b01, b}; end
                m_ext = 1'b0;
            end
        end else begin
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_brk = 1'b1;
            else if (b == 8'hE1) m_pause = 7;
            else if (b != 8'h00 && b != 8'hFF) begin em = 1'b1; ev = {2'b00, b}; end
        end
    endtask

    task automatic compare_model();
        chk("model.valid", event_valid, m_q.size() != 0);
        chk("model.data", event_data, (m_q.size() != 0) ? m_q[0] : 10'h000);
        chk("model.count", fifo_count, m_q.size());
        chk("model.shift", shift, m_held[9'h012] | m_held[9'h059]);
        chk("model.ctrl", ctrl, m_held[9'h014] | m_held[9'h114]);
        chk("model.alt", alt, m_held[9'h011] | m_held[9'h111]);
        chk("model.overflow", overflow, m_ovf);
    endtask

    // One clock: drive at the falling edge, update model at the rising edge,
    // compare shortly after.
    task automatic cycle(input bit sr, input logic [7:0] b, input bit er, input bit co);
        bit         pop, em, drop;
        logic [9:0] ev;
        @(negedge clk);
        scan_ready     = sr;
        scan_code      = b;
        event_ready    = er;
        clear_overflow = co;
        @(posedge clk);
        pop = er && (m_q.size() != 0);
        em  = 1'b0;
        ev  = '0;
        if (sr && !m_prev_sr) model_parse(b, em, ev);
        m_prev_sr = sr;
        if (em) m_held[ev[8:0]] = !ev[9];
        if (pop) void'(m_q.pop_front());
        drop = 1'b0;
        if (em) begin
            if (m_q.size() < DEPTH) m_q.push_back(ev);
            else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (co) m_ovf = 1'b0;
        #1;
        compare_model();
    endtask

    task automatic send(input logic [7:0] b, input bit er, input bit co);
        cycle(1'b1, b, er, co);
        cycle(1'b0, b, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n        = 1'b0;
        scan_ready     = 1'b0;
        event_ready    = 1'b0;
        clear_overflow = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    typedef struct {
        bit         sr;
        logic [7:0] b;
        bit         er;
        bit         v;
        logic [9:0] d;
        int         c;
        bit         s, ct, a;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit sr, input logic [7:0] b, input bit er, input bit v,
                                input logic [9:0] d, input int c, input bit s, input bit ct, input bit a);
        vec_t r;
        r.sr = sr; r.b = b; r.er = er; r.v = v; r.d = d; r.c = c; r.s = s; r.ct = ct; r.a = a;
        tbl.push_back(r);
    endfunction

    function automatic void B(input logic [7:0] b, input bit v, input logic [9:0] d, input int c,
                              input bit s, input bit ct, input bit a);
        add(1'b1, b, 1'b0, v, d, c, s, ct, a);
    endfunction

    function automatic void P(input bit v, input logic [9:0] d, input int c,
                              input bit s, input bit ct, input bit a);
        add(1'b0, 8'h00, 1'b1, v, d, c, s, ct, a);
    endfunction

    initial begin
        logic [7:0] codes [9];
        logic [7:0] b;
        int         r;

        codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};

        // Make/break and FIFO ordering.
        B(8'h1C, 1, 10'h01C, 1, 0, 0, 0);
        B(8'hF0, 1, 10'h01C, 1, 0, 0, 0);
        B(8'h1C, 1, 10'h01C, 2, 0, 0, 0);
        P(1, 10'h21C, 1, 0, 0, 0);
        P(0, 10'h000, 0, 0, 0, 0);
        // Extended make/break.
        B(8'hE0, 0, 10'h000, 0, 0, 0, 0);
        B(8'h75, 1, 10'h175, 1, 0, 0, 0);
        B(8'hE0, 1, 10'h175, 1, 0, 0, 0);
        B(8'hF0, 1, 10'h175, 1, 0, 0, 0);
        B(8'h75, 1, 10'h175, 2, 0, 0, 0);
        P(1, 10'h375, 1, 0, 0, 0);
        P(0, 10'h000, 0, 0, 0, 0);
        // Fake shift, then real shift/ctrl sequences.
        B(8'hE0, 0, 10'h000, 0, 0, 0, 0);
        B(8'h12, 0, 10'h000, 0, 0, 0, 0);
        B(8'h12, 1, 10'h012, 1, 1, 0, 0);
        P(0, 10'h000, 0, 1, 0, 0);
        B(8'hE0, 0, 10'h000, 0, 1, 0, 0);
        B(8'h14, 1, 10'h114, 1, 1, 1, 0);
        P(0, 10'h000, 0, 1, 1, 0);
        B(8'h59, 1, 10'h059, 1, 1, 1, 0);
        B(8'hF0, 1, 10'h059, 1, 1, 1, 0);
        B(8'h12, 1, 10'h059, 2, 1, 1, 0);
        B(8'hF0, 1, 10'h059, 2, 1, 1, 0);
        B(8'h59, 1, 10'h059, 3, 0, 1, 0);
        B(8'hE0, 1, 10'h059, 3, 0, 1, 0);
        B(8'hF0, 1, 10'h059, 3, 0, 1, 0);
        B(8'h14, 1, 10'h059, 4, 0, 0, 0);
        P(1, 10'h212, 3, 0, 0, 0);
        P(1, 10'h259, 2, 0, 0, 0);
        P(1, 10'h314, 1, 0, 0, 0);
        P(0, 10'h000, 0, 0, 0, 0);
        // Pause sequence collapses to a single event.
        B(8'hE1, 0, 10'h000, 0, 0, 0, 0);
        B(8'h14, 0, 10'h000, 0, 0, 0, 0);
        B(8'h77, 0, 10'h000, 0, 0, 0, 0);
        B(8'hE1, 0, 10'h000, 0, 0, 0, 0);
        B(8'hF0, 0, 10'h000, 0, 0, 0, 0);
        B(8'h14, 0, 10'h000, 0, 0, 0, 0);
        B(8'hF0, 0, 10'h000, 0, 0, 0, 0);
        B(8'h77, 1, 10'h177, 1, 0, 0, 0);
        P(0, 10'h000, 0, 0, 0, 0);
        // Error bytes dropped; a break of E0 is a plain break event.
        B(8'h00, 0, 10'h000, 0, 0, 0, 0);
        B(8'hFF, 0, 10'h000, 0, 0, 0, 0);
        B(8'hF0, 0, 10'h000, 0, 0, 0, 0);
        B(8'hE0, 1, 10'h2E0, 1, 0, 0, 0);
        // Alt pair: releasing the unheld right alt keeps left alt.
        B(8'h11, 1, 10'h2E0, 2, 0, 0, 1);
        B(8'hE0, 1, 10'h2E0, 2, 0, 0, 1);
        B(8'hF0, 1, 10'h2E0, 2, 0, 0, 1);
        B(8'h11, 1, 10'h2E0, 3, 0, 0, 1);
        B(8'hF0, 1, 10'h2E0, 3, 0, 0, 1);
        B(8'h11, 1, 10'h2E0, 4, 0, 0, 0);
        P(1, 10'h011, 3, 0, 0, 0);
        P(1, 10'h311, 2, 0, 0, 0);
        P(1, 10'h211, 1, 0, 0, 0);
        P(0, 10'h000, 0, 0, 0, 0);

        reset_n        = 1'b0;
        scan_ready     = 1'b0;
        scan_code      = 8'h00;
        event_ready    = 1'b0;
        clear_overflow = 1'b0;
        model_reset();
        #3;
        chk("reset.valid", event_valid, 1'b0);
        chk("reset.data", event_data, 10'h000);
        chk("reset.count", fifo_count, 4'd0);
        chk("reset.mods", {shift, ctrl, alt, overflow}, 4'b0000);
        #9 reset_n = 1'b1;
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            cycle(tbl[i].sr, tbl[i].b, tbl[i].er, 1'b0);
            chk($sformatf("vec%0d.valid", i), event_valid, tbl[i].v);
            chk($sformatf("vec%0d.data", i), event_data, tbl[i].d);
            chk($sformatf("vec%0d.count", i), fifo_count, tbl[i].c);
            chk($sformatf("vec%0d.mods", i), {shift, ctrl, alt}, {tbl[i].s, tbl[i].ct, tbl[i].a});
            if (tbl[i].sr) cycle(1'b0, tbl[i].b, 1'b0, 1'b0);
        end

        // Overflow: nine makes into an eight-deep queue with no consumer.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send(codes[i], 1'b0, 1'b0);
            if (i == 7) chk("ovf.before", overflow, 1'b0);
        end
        chk("ovf.count", fifo_count, 4'd8);
        chk("ovf.flag", overflow, 1'b1);
        chk("ovf.head", event_data, 10'h015);
        send(8'h4B, 1'b1, 1'b0);
        chk("ovf.pushpop.count", fifo_count, 4'd8);
        chk("ovf.pushpop.head", event_data, 10'h01D);
        send(8'h4D, 1'b0, 1'b1);
        chk("ovf.setwins", overflow, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf.clear", overflow, 1'b0);
        chk("ovf.clear.count", fifo_count, 4'd8);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("ovf.drained", event_valid, 1'b0);

        // Reset in the middle of E0 F0 with a held shift and a queued event.
        send(8'h12, 1'b0, 1'b0);
        send(8'hE0, 1'b0, 1'b0);
        send(8'hF0, 1'b0, 1'b0);
        chk("mid.pre.shift", shift, 1'b1);
        @(negedge clk);
        #2;
        reset_n    = 1'b0;
        scan_ready = 1'b1;
        scan_code  = 8'h1C;
        #1;
        chk("mid.async.valid", event_valid, 1'b0);
        chk("mid.async.count", fifo_count, 4'd0);
        chk("mid.async.shift", shift, 1'b0);
        chk("mid.async.data", event_data, 10'h000);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1'b1, 8'h1C, 1'b0, 1'b0);
        cycle(1'b1, 8'h1C, 1'b0, 1'b0);
        chk("mid.nocapture", event_valid, 1'b0);
        cycle(1'b0, 8'h1C, 1'b0, 1'b0);
        cycle(1'b1, 8'h1C, 1'b0, 1'b0);
        chk("mid.after.data", event_data, 10'h01C);
        chk("mid.after.count", fifo_count, 4'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic; the model comparison runs on every clock.
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 15);
            case (r)
                0, 1:    b = 8'hE0;
                2, 3:    b = 8'hF0;
                4:       b = 8'hE1;
                5:       b = 8'h12;
                6:       b = 8'h59;
                7:       b = 8'h14;
                8:       b = 8'h11;
                9:       b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
                default: b = 8'($urandom_range(0, 255));
            endcase
            cycle(1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Converts the byte stream from the PS/2 scan-code receiver into discrete key events in scan code set 2 and queues them for the consumer. Each event carries:

- make/break,
- extended (E0-prefixed),
- an 8-bit key code.

The block sits directly downstream of the receiver, in the same clock domain. It parses the E0 and F0 prefixes and swallows the 8-byte Pause sequence. It tracks shift/ctrl/alt state and buffers events in a small FIFO with a valid/ready output handshake.

## Interface

- FIFO_DEPTH, 8, event queue depth; power of two, ≥2
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- scan_ready  in  1  from receiver; level; a rising edge marks a new byte
- scan_code  in  8  from receiver; stable while scan_ready is high
- event_valid  out  1  FIFO not empty
- event_ready  in  1  consumer accepts head event when high with event_valid
- event_data  out  10  [9]=break, [8]=extended, [7:0]=key code; head of FIFO, show-ahead
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries
- shift  out  1  left (12) or right (59) shift held
- ctrl  out  1  left (14) or right (E0 14) ctrl held
- alt  out  1  left (11) or right (E0 11) alt held
- overflow  out  1  sticky; an event was dropped because the FIFO was full
- clear_overflow  in  1  synchronous clear of overflow

## Operation

Byte capture:
- scan_ready_q samples scan_ready every edge.
- A byte is accepted at an edge where scan_ready=1 and scan_ready_q=0. Exactly one acceptance per receiver frame.

Parser FSM (one step per accepted byte; all codes hex):
- IDLE:
  - E0 → EXT
  - F0 → BRK
  - E1 → PAUSE, skip=7
  - 00 or FF (keyboard error) → dropped, stay IDLE
  - anything else → emit {0,0,code}
- EXT:
  - F0 → EXT_BRK
  - E0 → stay EXT
  - 12 or 59 (fake shift) → dropped, → IDLE
  - else → emit {0,1,code}, → IDLE
- BRK: emit {1,0,code}, → IDLE. This applies to any byte, including E0/F0.
- EXT_BRK:
  - 12 or 59 → dropped, → IDLE
  - else → emit {1,1,code}, → IDLE
- PAUSE:
  - Decrement skip on each byte.
  - On the byte that makes skip 0: emit {0,1,77}, → IDLE.
  - No modifier updates occur during PAUSE.

Modifiers:
- Six internal flags: lshift, rshift, lctrl, rctrl, lalt, ralt.
- An emitted make sets its flag; an emitted break clears it.
- Updates happen on the same edge as emission, whether or not the FIFO accepts the event.
- Outputs are the OR of the left/right pair.

FIFO:
- Circular buffer with read/write pointers and a count.
- push = emission. pop = event_valid & event_ready.
- Push when full without a simultaneous pop: event dropped, overflow set. Count and contents are unchanged.
- Push and pop on the same edge while full: both occur, no overflow, count stays FIFO_DEPTH.
- Push and pop on the same edge while empty: impossible, since event_valid=0.
- Pointers wrap modulo FIFO_DEPTH.
- clear_overflow and a new overflow on the same edge: overflow stays 1 (set wins).

## Timing

- Reset (async assert, sync release):
  - FSM IDLE, skip=0
  - FIFO empty: event_valid=0, fifo_count=0
  - event_data=0
  - all modifier flags 0, overflow=0
  - scan_ready_q=1, so a scan_ready already high at release is not captured
- Reset mid-sequence (e.g. after E0 F0) discards the partial sequence. The next byte is parsed from IDLE.
- Latency: a byte accepted at edge k that emits into an empty FIFO gives event_valid=1 and event_data valid after edge k.
- Modifier outputs change after the same edge k.
- Pop at edge k: the next entry appears on event_data after edge k. If the FIFO empties, event_valid=0 after edge k.
- event_data is held stable while event_valid=1 and event_ready=0.
- Throughput: one byte accepted per scan_ready rising edge. No minimum spacing is required beyond one clk.

## Test plan

- Make/break: bytes 1C, F0 1C → events 01C then 21C; fifo_count 1→2; pop both → event_valid=0.
- Extended: E0 75, E0 F0 75 → 175 then 375. Fake shift E0 12 produces no event and shift stays 0.
- Modifiers: 12 → shift=1 after that edge. E0 14 → ctrl=1. 59 then F0 12 → shift still 1 (right shift held). F0 59 → shift=0. E0 F0 14 → ctrl=0.
- Pause: E1 14 77 E1 F0 14 F0 77 → exactly one event 177. ctrl stays 0 throughout.
- Overflow, FIFO_DEPTH=8, event_ready=0: send 9 make codes → fifo_count=8, overflow=1, head is the first code, the 9th is lost. On the 10th byte, pulse event_ready on the same edge → no new overflow, count stays 8. clear_overflow → overflow=0.
- Reset: assert reset_n=0 after E0 F0 → outputs reach reset values asynchronously. Hold scan_ready high through release → no capture. Then 1C → event 01C (not 31C).
